// File: rtl/vga_pkg.sv
// Shared screen geometry defaults and the fill state encoding.
package vga_pkg;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_COORD_W  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/raster_counter.sv
// x/y raster scan over an inclusive rectangle; x wraps to xl at xr and bumps y.
module raster_counter
    import vga_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] xl,
    input  logic [COORD_W-1:0] xr,
    input  logic [COORD_W-1:0] yt,
    input  logic [COORD_W-1:0] yb,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_xend;

    assign w_xend = (r_x == xr);
    assign last   = w_xend && (r_y == yb);
    assign x      = r_x;
    assign y      = r_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (load) begin
            r_x <= xl;
            r_y <= yt;
        end else if (advance) begin
            if (w_xend) begin
                r_x <= xl;
                r_y <= r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: orders and clips corners, then streams one pixel
// per ready handshake in raster order.
module rect_fill
    import vga_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int COLOR_W  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_write,
    output logic               busy,
    output logic               done
);
    localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);

    state_t             r_state;
    state_t             w_next;
    logic [COORD_W-1:0] r_xl, r_xr, r_yt, r_yb;
    logic [COLOR_W-1:0] r_color;
    logic [COORD_W-1:0] w_xl, w_xr_raw, w_xr, w_yt, w_yb_raw, w_yb;
    logic               w_empty, w_load, w_adv, w_last;

    assign w_xl     = (x0 < x1) ? x0 : x1;
    assign w_xr_raw = (x0 < x1) ? x1 : x0;
    assign w_yt     = (y0 < y1) ? y0 : y1;
    assign w_yb_raw = (y0 < y1) ? y1 : y0;
    assign w_xr     = (w_xr_raw > XMAX) ? XMAX : w_xr_raw;
    assign w_yb     = (w_yb_raw > YMAX) ? YMAX : w_yb_raw;
    assign w_empty  = (w_xl > XMAX) || (w_yt > YMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_xl    <= '0;
            r_xr    <= '0;
            r_yt    <= '0;
            r_yb    <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_xl    <= w_xl;
                r_xr    <= w_xr;
                r_yt    <= w_yt;
                r_yb    <= w_yb;
                r_color <= color_in;
            end
        end
    end

    // Abort wins over the scan; the final consume never advances so x/y stay on the last pixel.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = !w_empty;
                    w_next = w_empty ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort)                w_next = DONE;
                else if (ready && w_last) w_next = DONE;
                else                      w_adv  = ready;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The counter loads straight from the ordered corners so the first pixel appears one cycle after start.
    raster_counter #(.COORD_W(COORD_W)) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .advance (w_adv),
        .xl      (w_load ? w_xl : r_xl),
        .xr      (r_xr),
        .yt      (w_load ? w_yt : r_yt),
        .yb      (r_yb),
        .x       (x),
        .y       (y),
        .last    (w_last)
    );

    assign pixel_color = r_color;
    assign pixel_write = (r_state == RUN);
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  SCREEN_W  640  visible columns; valid x is 0..SCREEN_W-1
  SCREEN_H  480  visible rows; valid y is 0..SCREEN_H-1
  COORD_W   11   width of every coordinate port
  COLOR_W   1    width of the colour port
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk          in   1        single clock; all state changes on its rising edge
  reset_n      in   1        asynchronous, active-low reset
  start        in   1        request a fill; sampled only in IDLE
  abort        in   1        cancel the fill in progress
  x0, y0       in   COORD_W  first corner, inclusive
  x1, y1       in   COORD_W  opposite corner, inclusive
  color_in     in   COLOR_W  fill colour
  ready        in   1        downstream accepts the pixel this cycle
  x, y         out  COORD_W  current pixel coordinate
  pixel_color  out  COLOR_W  colour of the current pixel
  pixel_write  out  1        x, y and pixel_color are valid
  busy         out  1        a fill is in progress
  done         out  1        one-cycle completion pulse
REQ-003 One clock and one reset only; reset_n is asynchronous and active-low.

Function
REQ-004 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-005 In IDLE, start=1 SHALL latch the corners and color_in.
  - Corners are ordered so that xl=min(x0,x1), xr=max(x0,x1), yt=min(y0,y1), yb=max(y0,y1).
  - Corners are then clipped: xr to min(xr, SCREEN_W-1), yb to min(yb, SCREEN_H-1).
REQ-006 If xl>=SCREEN_W or yt>=SCREEN_H after ordering, the fill is empty.
  - IDLE goes directly to DONE.
  - pixel_write stays 0 for the whole request.
REQ-007 Otherwise the block SHALL enter RUN with x=xl, y=yt and pixel_write=1 on the next cycle; start-to-first-pixel latency is 1 cycle.
REQ-008 In RUN, a pixel is consumed when pixel_write=1 and ready=1 in the same cycle.
  - x advances by 1 on consume.
  - At x==xr, x wraps to xl and y increments.
  - The consume at (xr, yb) moves the block to DONE.
REQ-009 In RUN with ready=0, x, y and pixel_color SHALL hold and pixel_write SHALL stay 1; the block never drops or skips a pixel.
REQ-010 pixel_color SHALL equal the latched colour for the whole fill; changes on the input ports during RUN have no effect.
REQ-011 abort=1 in RUN SHALL move the block to DONE on the next edge.
  - pixel_write is 0 from that edge on.
  - A pixel consumed in the abort cycle still counts.
  - abort has priority over advancing the scan.
REQ-012 DONE SHALL last exactly 1 cycle.
  - done=1, busy=0, pixel_write=0.
  - The next state is always IDLE.
  - start is ignored during DONE.
REQ-013 busy=1 in RUN only; start during RUN is ignored.
REQ-014 Pixels per fill SHALL be (xr-xl+1)*(yb-yt+1). Each coordinate is emitted once, in raster order (left to right, top to bottom).
REQ-015 Coordinate arithmetic SHALL be done in COORD_W bits. Clipping guarantees no wrap past 2**COORD_W-1.

Reset
REQ-016 While reset_n=0, independent of clk, the block SHALL force:
  - state=IDLE
  - x=0, y=0, pixel_color=0
  - pixel_write=0, busy=0, done=0
REQ-017 Reset asserted during RUN SHALL end the fill with no done pulse.
REQ-018 After reset_n rises, the block SHALL accept start on the first clock edge.

Structure
REQ-019 A shared package (vga_pkg) SHALL hold:
  - the state enum (IDLE, RUN, DONE)
  - SCREEN_W, SCREEN_H and COORD_W default constants
REQ-020 One sub-module, raster_counter, SHALL hold the x/y wrap counter, with inputs load, advance, xl, xr, yt, yb and output last.
  - rect_fill owns the state machine, corner ordering, clipping and the handshake.

Verification
REQ-021 Full screen: start with corners (0,0)-(639,479), ready=1 -> 307200 writes, last at (639,479), done one cycle later, no gaps.
REQ-022 Swapped corners: corners (5,3)-(2,1) -> 12 writes in order (2,1)..(5,1),(2,2)..(5,3).
REQ-023 Clipping: corners (630,470)-(700,500) -> 100 writes, x in 630..639, y in 470..479. Corners (650,0)-(700,10) -> no write, done 1 cycle after start.
REQ-024 Backpressure: corners (0,0)-(3,0) with ready toggling 1,0,0,1,... -> outputs hold while ready=0; exactly the 4 writes x=0..3; done after the last consume.
REQ-025 Abort and reset: abort on the 10th consume -> exactly 10 writes then done. In a separate run, reset_n=0 mid-fill -> outputs clear immediately, no done pulse, the next start works.
